// File: rtl/soc_system_clk_pkg.sv
// -----------------------------------------------------------------------------
// soc_system_clk_pkg
// Shared types for the soc_system clock-enable/divider block.
//   CFG_W        : width of the div / high / phase fields
//   CHAN_W       : width of the configuration channel index
//   clk_state_e  : lock/settle FSM states
//   chan_cfg_t   : per-channel configuration {div, high, phase}
//   restart_value: counter value a channel loads on restart
// -----------------------------------------------------------------------------
package soc_system_clk_pkg;

    localparam int CFG_W  = 16;
    localparam int CHAN_W = 4;

    typedef enum logic [1:0] {
        WAIT_REF = 2'd0,
        SETTLE   = 2'd1,
        LOCKED   = 2'd2
    } clk_state_e;

    typedef struct packed {
        logic [CFG_W-1:0] div;    // period minus one
        logic [CFG_W-1:0] high;   // cycles high per period
        logic [CFG_W-1:0] phase;  // counter start value
    } chan_cfg_t;

    // A phase beyond the period would never be reached by the wrap logic,
    // so such a channel starts from the top of its period instead.
    function automatic logic [CFG_W-1:0] restart_value(input chan_cfg_t c);
        return (c.phase > c.div) ? '0 : c.phase;
    endfunction

endpackage

// File: rtl/soc_system_clk_div_chan.sv
// -----------------------------------------------------------------------------
// soc_system_clk_div_chan
// One divider channel: period counter, restart/hold control, output decode.
//   i_clk      : fabric clock
//   i_rst      : asynchronous active-high reset
//   i_run      : channel is running this cycle (FSM in LOCKED)
//   i_run_nxt  : channel runs next cycle (FSM enters/stays in LOCKED)
//   i_cfg      : shadow configuration, latched into the active copy on restart
//   o_clk_out  : divided waveform, registered, aligned to the counter
//   o_clk_en   : one-cycle pulse when the counter is 0
// -----------------------------------------------------------------------------
module soc_system_clk_div_chan
    import soc_system_clk_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_run,
    input  logic      i_run_nxt,
    input  chan_cfg_t i_cfg,
    output logic      o_clk_out,
    output logic      o_clk_en
);

    chan_cfg_t        r_act;
    logic [CFG_W-1:0] r_cnt;
    logic             r_clk_out;
    logic             r_clk_en;

    logic             w_keep;
    chan_cfg_t        w_cfg;
    logic [CFG_W-1:0] w_cnt_nxt;

    // While held, the channel keeps tracking the shadow registers so that the
    // first running cycle already carries the restart value and its decode.
    // Once running, only the active copy is used, so shadow writes never
    // disturb a period in progress.
    always_comb begin
        w_keep = i_run & i_run_nxt;
        w_cfg  = w_keep ? r_act : i_cfg;
        if (w_keep) begin
            w_cnt_nxt = (r_cnt == r_act.div) ? '0 : r_cnt + CFG_W'(1);
        end else begin
            w_cnt_nxt = restart_value(i_cfg);
        end
    end

    // Outputs are decoded from the next counter value and registered with it,
    // so o_clk_out/o_clk_en describe r_cnt in the same cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_act     <= '0;
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_clk_en  <= 1'b0;
        end else begin
            r_act     <= w_cfg;
            r_cnt     <= w_cnt_nxt;
            r_clk_out <= i_run_nxt & (w_cnt_nxt < w_cfg.high);
            r_clk_en  <= i_run_nxt & (w_cnt_nxt == '0);
        end
    end

    assign o_clk_out = r_clk_out;
    assign o_clk_en  = r_clk_en;

endmodule

// File: rtl/soc_system_clk_div_n.sv
// -----------------------------------------------------------------------------
// soc_system_clk_div_n
// Multi-channel clock-enable/divider generator behind the HPS-fabric PLL.
// Owns the ref_locked synchroniser, lock/settle FSM, settle counter and the
// per-channel shadow configuration; channels are soc_system_clk_div_chan.
//   i_refclk      : fabric clock (only clock)
//   i_rst         : asynchronous active-high reset
//   i_ref_locked  : upstream PLL lock, asynchronous
//   i_cfg_valid   : configuration write request
//   o_cfg_ready   : write accepted when high with i_cfg_valid (low in SETTLE)
//   i_cfg_chan    : target channel (out-of-range writes are dropped)
//   i_cfg_div     : period minus one
//   i_cfg_high    : high time in cycles
//   i_cfg_phase   : counter start value on restart
//   i_cfg_apply   : with an accepted write in LOCKED, restarts all channels
//   o_clk_out     : divided waveform per channel
//   o_clk_en      : period-start pulse per channel
//   o_locked      : all channels running and aligned
// -----------------------------------------------------------------------------
module soc_system_clk_div_n
    import soc_system_clk_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int CNT_W        = CFG_W,  // must match CFG_W of the package
    parameter int LOCK_CYCLES  = 256,
    parameter int SYNC_STAGES  = 2,
    parameter int DEFAULT_DIV  = 1,
    parameter int DEFAULT_HIGH = 1
) (
    input  logic                    i_refclk,
    input  logic                    i_rst,
    input  logic                    i_ref_locked,
    input  logic                    i_cfg_valid,
    output logic                    o_cfg_ready,
    input  logic [CHAN_W-1:0]       i_cfg_chan,
    input  logic [CNT_W-1:0]        i_cfg_div,
    input  logic [CNT_W-1:0]        i_cfg_high,
    input  logic [CNT_W-1:0]        i_cfg_phase,
    input  logic                    i_cfg_apply,
    output logic [NUM_CHANNELS-1:0] o_clk_out,
    output logic [NUM_CHANNELS-1:0] o_clk_en,
    output logic                    o_locked
);

    localparam int SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] r_sync;
    clk_state_e             r_state;
    logic [SET_W-1:0]       r_settle;
    chan_cfg_t              r_shadow [NUM_CHANNELS];

    logic                   w_ref_sync;
    logic                   w_accept;
    logic                   w_settle_done;
    clk_state_e             w_state_nxt;
    logic                   w_run;
    logic                   w_run_nxt;

    // ---------------------------------------------------------------- sync
    always_ff @(posedge i_refclk or posedge i_rst) begin
        if (i_rst) r_sync <= '0;
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_ref_locked};
    end

    assign w_ref_sync    = r_sync[SYNC_STAGES-1];
    assign o_cfg_ready   = (r_state != SETTLE);
    assign w_accept      = i_cfg_valid & o_cfg_ready;
    assign w_settle_done = (r_settle == SET_W'(LOCK_CYCLES - 1));

    // ----------------------------------------------------------------- FSM
    always_ff @(posedge i_refclk or posedge i_rst) begin
        if (i_rst) r_state <= WAIT_REF;
        else       r_state <= w_state_nxt;
    end

    // Loss of lock overrides everything, including a simultaneous apply.
    always_comb begin
        w_state_nxt = r_state;
        if (!w_ref_sync) begin
            w_state_nxt = WAIT_REF;
        end else begin
            case (r_state)
                WAIT_REF: w_state_nxt = SETTLE;
                SETTLE:   if (w_settle_done) w_state_nxt = LOCKED;
                LOCKED:   if (w_accept && i_cfg_apply) w_state_nxt = SETTLE;
                default:  w_state_nxt = WAIT_REF;
            endcase
        end
    end

    // Counter restarts at 0 on every entry into SETTLE (from WAIT_REF or an
    // apply in LOCKED); it only advances while SETTLE persists.
    always_ff @(posedge i_refclk or posedge i_rst) begin
        if (i_rst) begin
            r_settle <= '0;
        end else if (r_state == SETTLE && w_state_nxt == SETTLE) begin
            r_settle <= r_settle + SET_W'(1);
        end else begin
            r_settle <= '0;
        end
    end

    assign w_run     = (r_state == LOCKED);
    assign w_run_nxt = (w_state_nxt == LOCKED);
    assign o_locked  = w_run;

    // -------------------------------------------------------------- shadows
    always_ff @(posedge i_refclk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_shadow[i].div   <= CFG_W'(DEFAULT_DIV);
                r_shadow[i].high  <= CFG_W'(DEFAULT_HIGH);
                r_shadow[i].phase <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                // Indices with no channel never match, so those writes drop.
                if (w_accept && i_cfg_chan == CHAN_W'(i)) begin
                    r_shadow[i].div   <= i_cfg_div;
                    r_shadow[i].high  <= i_cfg_high;
                    r_shadow[i].phase <= i_cfg_phase;
                end
            end
        end
    end

    // ------------------------------------------------------------- channels
    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
        soc_system_clk_div_chan u_chan (
            .i_clk     (i_refclk),
            .i_rst     (i_rst),
            .i_run     (w_run),
            .i_run_nxt (w_run_nxt),
            .i_cfg     (r_shadow[g]),
            .o_clk_out (o_clk_out[g]),
            .o_clk_en  (o_clk_en[g])
        );
    end

endmodule

// File: doc/soc_system_clk_div_n.md
# soc_system_clk_div_n

Parametrised multi-channel clock-enable/divider generator that sits directly behind the HPS-fabric PLL in the soc_system clock tree. From one fabric clock it derives NUM_CHANNELS phase-aligned divided waveforms and one-cycle enable pulses. Each channel has a runtime-programmable period, high time and phase. A `locked` output is qualified by the upstream PLL lock and a settle interval, so downstream logic (servo PWM, ADC sampling) sees only clean, aligned timing after reset, lock loss or reconfiguration.

## Interface
- NUM_CHANNELS, 4: number of divider channels (1..16).
- CNT_W, 16: width of the divide, high-time and phase fields.
- LOCK_CYCLES, 256: settle interval in refclk cycles before `locked` asserts (≥1).
- SYNC_STAGES, 2: synchroniser depth on `ref_locked` (≥2).
- DEFAULT_DIV, 1: reset value of every channel's div field (period = div+1).
- DEFAULT_HIGH, 1: reset value of every channel's high-time field.
- refclk  in  1  fabric clock; the only clock in the block.
- rst  in  1  asynchronous, active-high reset.
- ref_locked  in  1  upstream PLL lock, asynchronous to refclk.
- cfg_valid  in  1  configuration write request.
- cfg_ready  out  1  configuration write accepted when high together with cfg_valid.
- cfg_chan  in  4  target channel index.
- cfg_div  in  CNT_W  period minus one.
- cfg_high  in  CNT_W  high-time in cycles.
- cfg_phase  in  CNT_W  counter start value on restart.
- cfg_apply  in  1  with an accepted write, triggers a global restart.
- clk_out  out  NUM_CHANNELS  divided waveform per channel.
- clk_en  out  NUM_CHANNELS  one-cycle pulse at each channel's period start.
- locked  out  1  all channels running and aligned.

## Operation
- Reset values: clk_out=0, clk_en=0, locked=0, cfg_ready=1. Shadow registers hold div=DEFAULT_DIV, high=DEFAULT_HIGH, phase=0. FSM is in WAIT_REF.
- The `ref_locked` input passes through a SYNC_STAGES flop synchroniser before use; this synchronised signal is `ref_sync`.
- FSM:
  - WAIT_REF: counters are held at phase and outputs are 0. Moves to SETTLE when ref_sync=1.
  - SETTLE: the settle counter runs from 0 to LOCK_CYCLES-1, counters stay held, and cfg_ready=0. Moves to LOCKED at the end of the count.
  - LOCKED: counters run, locked=1, cfg_ready=1.
  - From any state, ref_sync=0 forces WAIT_REF on the next edge. locked, clk_out and clk_en drop in that same cycle.
- Config handshake:
  - A write transfers on cfg_valid&cfg_ready and updates the shadow registers of cfg_chan.
  - cfg_chan ≥ NUM_CHANNELS: the write is accepted and discarded.
  - An accepted write with cfg_apply=1 in LOCKED sends the FSM to SETTLE, which reloads all channels simultaneously.
  - In WAIT_REF, cfg_apply is ignored because the next lock restarts all channels anyway.
  - Writes without apply take effect only at the next restart. Running channels never change mid-period.
- Channel counter:
  - Restart loads cnt=phase. If phase>div, cnt loads 0.
  - Running: cnt increments each cycle and wraps to 0 when it reaches div.
  - clk_out=(cnt<high). high=0 gives constant 0; high>div gives constant 1.
  - clk_en=(cnt==0).
  - div=0 gives period 1: clk_en=1 every cycle.
- Arithmetic is unsigned CNT_W. No sum exceeds CNT_W.

## Timing
- ref_locked rising to FSM entering SETTLE takes SYNC_STAGES+1 edges. SETTLE lasts exactly LOCK_CYCLES cycles.
- The first LOCKED cycle has locked=1, and every channel has cnt=phase with outputs decoded from that value in the same cycle. Outputs are registered and aligned to cnt.
- ref_locked falling to locked=0 takes SYNC_STAGES+1 edges.
- Accepted apply write to locked=0 and cfg_ready=0 takes 1 edge.
- Simultaneous ref_sync fall and apply write: the write is stored and the FSM goes to WAIT_REF.
- Async rst mid-operation clears everything immediately to the reset values.

## Structure
- A shared package, soc_system_clk_pkg, holds the FSM state enum (WAIT_REF, SETTLE, LOCKED) and a channel-config struct {div, high, phase}.
- One sub-module, soc_system_clk_div_chan, contains a single channel: counter, restart/hold inputs and output decode. The top level instantiates it in a generate loop and owns the synchroniser, FSM, settle counter and shadow registers.

## Test plan
- Reset, then ref_locked=1 held → locked rises exactly SYNC_STAGES+1+LOCK_CYCLES edges later; all channels show clk_out 10 repeating and clk_en every 2 cycles.
- Channel 0: div=3, high=2, phase=0, apply → after settle, clk_out=1100 repeating and clk_en every 4 cycles aligned to the first 1.
- Ch0 phase=0 and ch1 phase=2, both div=3 and high=2 → ch1 waveform leads ch0 by 2 cycles; clk_en pulses are 2 cycles apart every period.
- Boundaries: high=0 → constant 0; high=5 with div=3 → constant 1; div=0 → clk_en constant 1; phase=9 with div=3 → starts at cnt=0; cfg_chan=15 with NUM_CHANNELS=4 → accepted, no shadow register changes.
- In LOCKED, drop ref_locked for 10 cycles → locked=0 and outputs go to 0 after SYNC_STAGES+1 edges; recovery repeats the full settle and outputs restart aligned.
- Apply write during SETTLE → cfg_ready=0 and the write stalls until LOCKED; assert rst mid-SETTLE → all outputs go to 0 immediately and shadow registers return to defaults.
